// File: rtl/if_id_reg.sv
// IF/ID pipeline register for the five-stage RV32I pipeline.
// Captures the fetched instruction and PC, supports stall (hold) and flush
// (bubble insertion), and drives register indices, immediate slices and the
// one-hot immediate-format select from the registered instruction.
// Optional feature macro: IF_ID_BUBBLE_CNT_EN (adds a 32-bit flush counter).
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] PC_RESET  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instrF,
  input  logic [31:0] pcF,
  input  logic        stallD,
  input  logic        flushD,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic        validD,
  output logic [4:0]  rs1D,
  output logic [4:0]  rs2D,
  output logic [4:0]  rdD,
  output logic [4:0]  iimm_shamt,
  output logic [11:0] iimm,
  output logic [11:0] simm,
  output logic [11:0] bimm,
  output logic [19:0] uimm,
  output logic [19:0] jimm,
  output logic [5:0]  EXTOp,
  output logic [31:0] bubble_cnt
);

  // Opcodes that select an immediate format
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  // One-hot immediate-format encodings
  localparam logic [5:0] ExtShamt = 6'b100000;
  localparam logic [5:0] ExtI     = 6'b010000;
  localparam logic [5:0] ExtS     = 6'b001000;
  localparam logic [5:0] ExtB     = 6'b000100;
  localparam logic [5:0] ExtU     = 6'b000010;
  localparam logic [5:0] ExtJ     = 6'b000001;
  localparam logic [5:0] ExtNone  = 6'b000000;

  logic [6:0] opcode;
  logic [2:0] funct3;

  // Pipeline register: reset > flush > stall > load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrD <= NOP_INSTR;
      pcD    <= PC_RESET;
      validD <= 1'b0;
    end else if (flushD) begin
      instrD <= NOP_INSTR;
      pcD    <= PC_RESET;
      validD <= 1'b0;
    end else if (!stallD) begin
      instrD <= instrF;
      pcD    <= pcF;
      validD <= 1'b1;
    end
  end

`ifdef IF_ID_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q;

  // Counts every flush edge, stalled or not; wraps naturally at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= 32'b0;
    end else if (flushD) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  assign bubble_cnt = 32'b0;
`endif

  // Field slices are pure wiring from the registered instruction
  assign opcode     = instrD[6:0];
  assign funct3     = instrD[14:12];
  assign rs1D       = instrD[19:15];
  assign rs2D       = instrD[24:20];
  assign rdD        = instrD[11:7];
  assign iimm_shamt = instrD[24:20];
  assign iimm       = instrD[31:20];
  assign simm       = {instrD[31:25], instrD[11:7]};
  assign bimm       = {instrD[31], instrD[7], instrD[30:25], instrD[11:8]};
  assign uimm       = instrD[31:12];
  assign jimm       = {instrD[31], instrD[19:12], instrD[20], instrD[30:21]};

  // Immediate-format decode; each arm yields at most one set bit
  always_comb begin
    EXTOp = ExtNone;
    case (opcode)
      OpImm: begin
        // slli/srli/srai use the shamt field, not a 12-bit immediate
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          EXTOp = ExtShamt;
        end else begin
          EXTOp = ExtI;
        end
      end
      OpLoad, OpJalr:  EXTOp = ExtI;
      OpStore:         EXTOp = ExtS;
      OpBranch:        EXTOp = ExtB;
      OpLui, OpAuipc:  EXTOp = ExtU;
      OpJal:           EXTOp = ExtJ;
      default:         EXTOp = ExtNone;
    endcase
  end

endmodule
